// File: rtl/router_pkt_reg.sv
// Packet register stage: header/length tracking FSM, running parity check and a
// small circular holding buffer that forwards every accepted byte in order.
module router_pkt_reg #(
    parameter int DW          = 8,
    parameter int HOLD_DEPTH  = 4,
    parameter int PARITY_MODE = 0,
    parameter int LEN_CHECK   = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [1:0]    dest,
    output logic          dest_valid,
    output logic          parity_done,
    output logic          err,
    output logic          len_err
);
    localparam int AW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW = DW - 2;
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(HOLD_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] LEN_ONE = CW'(1);

    typedef enum logic [1:0] {S_HDR, S_PAY, S_PAR, S_DISCARD} state_t;

    state_t        r_state, w_state_next;
    logic [DW-1:0] r_acc;
    logic [CW-1:0] r_cnt, r_len;
    logic [1:0]    r_dest;
    logic          r_dest_valid, r_parity_done, r_err, r_len_err;

    logic [DW:0]   r_mem [HOLD_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_next;
    logic          r_in_ready;

    logic          w_accept, w_pop;
    logic          w_hdr, w_runt, w_pay, w_par, w_len_set, w_push, w_push_last;
    logic [DW-1:0] w_acc_upd;
    logic [CW-1:0] w_hdr_len, w_cnt_inc;

    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = (r_count != '0) & out_ready;
    assign w_hdr_len = in_data[DW-1:2];
    assign w_cnt_inc = r_cnt + LEN_ONE;
    assign w_acc_upd = (PARITY_MODE == 1) ? (r_acc + in_data) : (r_acc ^ in_data);

    always_comb begin
        w_state_next = r_state;
        w_hdr        = 1'b0;
        w_runt       = 1'b0;
        w_pay        = 1'b0;
        w_par        = 1'b0;
        w_len_set    = 1'b0;
        w_push       = 1'b0;
        w_push_last  = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    w_hdr       = 1'b1;
                    w_push      = 1'b1;
                    w_push_last = in_last;
                    if (in_last)
                        w_runt = 1'b1;
                    else if (LEN_CHECK == 1 && w_hdr_len == '0)
                        w_state_next = S_PAR;
                    else
                        w_state_next = S_PAY;
                end
                S_PAY: begin
                    w_push = 1'b1;
                    if (in_last) begin
                        w_par        = 1'b1;
                        w_push_last  = 1'b1;
                        w_len_set    = (LEN_CHECK == 1) && (r_cnt != r_len);
                        w_state_next = S_HDR;
                    end else begin
                        w_pay = 1'b1;
                        if (LEN_CHECK == 1 && w_cnt_inc == r_len)
                            w_state_next = S_PAR;
                    end
                end
                S_PAR: begin
                    w_push       = 1'b1;
                    w_push_last  = 1'b1;
                    w_par        = 1'b1;
                    w_len_set    = !in_last;
                    w_state_next = in_last ? S_HDR : S_DISCARD;
                end
                default: begin
                    if (in_last)
                        w_state_next = S_HDR;
                end
            endcase
        end
    end

    // Header and parity can never be accepted in the same cycle, so the
    // sticky-flag updates below are mutually exclusive.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_HDR;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_len         <= '0;
            r_dest        <= '0;
            r_dest_valid  <= 1'b0;
            r_parity_done <= 1'b0;
            r_err         <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_hdr) begin
                r_dest        <= in_data[1:0];
                r_len         <= w_hdr_len;
                r_acc         <= in_data;
                r_cnt         <= '0;
                r_parity_done <= w_runt;
                r_err         <= w_runt;
                r_len_err     <= w_runt;
                r_dest_valid  <= !w_runt;
            end
            if (w_pay) begin
                r_acc <= w_acc_upd;
                r_cnt <= w_cnt_inc;
            end
            if (w_par) begin
                r_parity_done <= 1'b1;
                r_err         <= (in_data != r_acc);
                r_dest_valid  <= 1'b0;
            end
            if (w_len_set)
                r_len_err <= 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_ONE;
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_push_last, in_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != CNT_FULL);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != '0);
    assign {out_last, out_data} = r_mem[r_rd_ptr];
    assign dest        = r_dest;
    assign dest_valid  = r_dest_valid;
    assign parity_done = r_parity_done;
    assign err         = r_err;
    assign len_err     = r_len_err;
endmodule

// File: tb/tb_router_pkt_reg.sv
// Scoreboard bench: an XOR-parity and a sum-parity instance see identical stimulus;
// expected bytes are queued by the driver and checked by a negedge monitor.
module tb_router_pkt_reg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_x, out_valid_x, out_last_x, dest_valid_x, pd_x, err_x, len_err_x;
    logic [7:0] out_data_x;
    logic [1:0] dest_x;
    logic       in_ready_s, out_valid_s, out_last_s, dest_valid_s, pd_s, err_s, len_err_s;
    logic [7:0] out_data_s;
    logic [1:0] dest_s;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    always #5 clk = ~clk;

    router_pkt_reg #(.DW(8), .HOLD_DEPTH(4), .PARITY_MODE(0), .LEN_CHECK(1)) dut_xor (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_x), .out_valid(out_valid_x), .out_data(out_data_x), .out_last(out_last_x),
        .out_ready(out_ready), .dest(dest_x), .dest_valid(dest_valid_x), .parity_done(pd_x),
        .err(err_x), .len_err(len_err_x));

    router_pkt_reg #(.DW(8), .HOLD_DEPTH(4), .PARITY_MODE(1), .LEN_CHECK(1)) dut_sum (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s), .out_last(out_last_s),
        .out_ready(out_ready), .dest(dest_s), .dest_valid(dest_valid_s), .parity_done(pd_s),
        .err(err_s), .len_err(len_err_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // status vector = {dest[1:0], dest_valid, parity_done, err, len_err}
    task automatic chk_status(input string name, input logic [1:0] d, input logic dv,
                              input logic pd, input logic e_x, input logic e_s, input logic le);
        chk({name, "/xor"}, {dest_x, dest_valid_x, pd_x, err_x, len_err_x}, {d, dv, pd, e_x, le});
        chk({name, "/sum"}, {dest_s, dest_valid_s, pd_s, err_s, len_err_s}, {d, dv, pd, e_s, le});
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit exp_push, input bit exp_last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready_x && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_x) begin
            fail_now("send_wait");
        end else begin
            if (exp_push) sb.push_back({exp_last, d});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid_x && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got 0x%0h last %0b, expected nothing", out_data_x, out_last_x);
            end else begin
                mon_exp = sb.pop_front();
                $display("out: data 0x%02h last %0b (expected 0x%02h last %0b)",
                         out_data_x, out_last_x, mon_exp[7:0], mon_exp[8]);
                chk("out/xor", {out_last_x, out_data_x}, mon_exp);
                chk("out/sum", {out_last_s, out_data_s}, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {in_ready_x, in_ready_s}, 2'b00);
        chk("rst_out_valid", {out_valid_x, out_valid_s}, 2'b00);
        chk_status("rst_status", 2'd0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", {in_ready_x, in_ready_s}, 2'b11);
        out_ready = 1'b1;

        // basic packet: xor parity 0x0D matches, sum parity is 0x73
        send(8'h0D, 0, 1, 0);
        chk_status("hdr_a", 2'd1, 1, 0, 0, 0, 0);
        send(8'h11, 0, 1, 0);
        send(8'h22, 0, 1, 0);
        send(8'h33, 0, 1, 0);
        send(8'h0D, 1, 1, 1);
        chk_status("pkt_a", 2'd1, 0, 1, 0, 1, 0);
        drain();

        // parity 0x73 (sum ok), header clears the sticky flags
        send(8'h0D, 0, 1, 0);
        chk_status("hdr_b", 2'd1, 1, 0, 0, 0, 0);
        send(8'h11, 0, 1, 0);
        send(8'h22, 0, 1, 0);
        send(8'h33, 0, 1, 0);
        send(8'h73, 1, 1, 1);
        chk_status("pkt_b", 2'd1, 0, 1, 1, 0, 0);
        send(8'h0D, 0, 1, 0);
        send(8'h11, 0, 1, 0);
        send(8'h22, 0, 1, 0);
        send(8'h33, 0, 1, 0);
        send(8'h74, 1, 1, 1);
        chk_status("pkt_c", 2'd1, 0, 1, 1, 1, 0);
        drain();

        // backpressure: buffer fills after four bytes, then drains across the wrap
        out_ready = 1'b0;
        send(8'h0D, 0, 1, 0);
        send(8'h11, 0, 1, 0);
        send(8'h22, 0, 1, 0);
        chk("in_ready_3", in_ready_x, 1'b1);
        send(8'h33, 0, 1, 0);
        chk("in_ready_full", {in_ready_x, in_ready_s}, 2'b00);
        chk("out_valid_full", out_valid_x, 1'b1);
        fork
            begin
                send(8'h0D, 1, 1, 1);
                send(8'h04, 0, 1, 0);
                send(8'h5A, 0, 1, 0);
                send(8'h5E, 1, 1, 1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk_status("pkt_wrap", 2'd0, 0, 1, 0, 0, 0);
        drain();

        // in_last on the second payload byte of an L=3 packet
        send(8'h0D, 0, 1, 0);
        send(8'h11, 0, 1, 0);
        send(8'h1C, 1, 1, 1);
        chk_status("pkt_short", 2'd1, 0, 1, 0, 1, 1);
        drain();

        // L=2 packet overrun: 0x3A is the parity byte, the rest are discarded
        send(8'h09, 0, 1, 0);
        send(8'h11, 0, 1, 0);
        send(8'h22, 0, 1, 0);
        send(8'h3A, 0, 1, 1);
        chk_status("pkt_long_par", 2'd1, 0, 1, 0, 1, 1);
        send(8'h55, 0, 0, 0);
        send(8'h66, 1, 0, 0);
        chk_status("pkt_long_end", 2'd1, 0, 1, 0, 1, 1);
        drain();

        // runt header
        send(8'h05, 1, 1, 1);
        chk_status("runt", 2'd1, 0, 1, 1, 1, 1);
        drain();

        // reset in the middle of a buffered packet
        out_ready = 1'b0;
        send(8'h0E, 0, 1, 0);
        send(8'h11, 0, 1, 0);
        chk_status("mid_pkt", 2'd2, 1, 0, 0, 0, 0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_in_ready", {in_ready_x, in_ready_s}, 2'b00);
        chk("mid_rst_out_valid", {out_valid_x, out_valid_s}, 2'b00);
        chk_status("mid_rst_status", 2'd0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {in_ready_x, in_ready_s}, 2'b11);
        chk("post_rst_out_valid", {out_valid_x, out_valid_s}, 2'b00);
        out_ready = 1'b1;

        // fresh packet after reset starts from the header state
        send(8'h04, 0, 1, 0);
        send(8'h5A, 0, 1, 0);
        send(8'h5E, 1, 1, 1);
        chk_status("post_rst_pkt", 2'd0, 0, 1, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/router_pkt_reg.md
# router_pkt_reg

Parametrised packet register stage for the router datapath, sitting between the source-side input and the destination FIFOs. It generalises the single-byte router register: data width, parity mode and holding depth are configurable, and it replaces the single "full" byte with a HOLD_DEPTH-entry holding buffer. It also adds its own header/length tracking FSM, a length checker and sticky per-packet status. Every accepted byte, parity byte included, is forwarded in order; the parity byte is tagged out_last.

## Interface
- DW, 8: data width in bits, ≥4; header bits [1:0] = destination, [DW-1:2] = payload length L
- HOLD_DEPTH, 4: holding buffer entries, ≥2, power of two
- PARITY_MODE, 0: 0 = XOR of header and payload; 1 = sum of header and payload mod 2^DW
- LEN_CHECK, 1: 1 = use header L to locate the parity byte; 0 = parity byte located by in_last only
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input byte valid
- in_data  in  DW  input byte
- in_last  in  1  marks parity byte
- in_ready  out  1  holding buffer not full; byte accepted when in_valid & in_ready
- out_valid  out  1  holding buffer not empty
- out_data  out  DW  buffer head byte
- out_last  out  1  head byte is a parity byte
- out_ready  in  1  destination FIFO not full; byte popped when out_valid & out_ready
- dest  out  2  destination captured from the header
- dest_valid  out  1  high from the header acceptance until parity_done
- parity_done  out  1  sticky: parity byte processed; cleared by the next header
- err  out  1  sticky: parity mismatch; cleared by the next header
- len_err  out  1  sticky: length mismatch; cleared by the next header

## Operation
- FSM states: S_HDR, S_PAY, S_PAR, S_DISCARD. Reset enters S_HDR.
- S_HDR: an accepted byte is the header. Capture dest and L, seed acc = header, clear parity_done/err/len_err, set dest_valid.
  - Next state: if in_last = 1, go to S_HDR (runt packet, below). Else if LEN_CHECK = 1 and L = 0, go to S_PAR. Else go to S_PAY.
  - Runt packet (header carries in_last = 1): parity_done = err = len_err = 1, dest_valid = 0.
- S_PAY: each accepted byte updates acc (^ or + per PARITY_MODE) and increments cnt (width DW-2).
  - in_last = 1: byte is the parity byte. Compare it to acc. When LEN_CHECK = 1, set len_err if cnt ≠ L (count before increment). Go to S_HDR.
  - LEN_CHECK = 1 and cnt reaches L with in_last = 0: go to S_PAR.
- S_PAR: the next accepted byte is the parity byte regardless of in_last. Compare it to acc.
  - in_last = 1: go to S_HDR.
  - in_last = 0: set len_err and go to S_DISCARD.
- S_DISCARD: accepted bytes are dropped, not pushed to the buffer, and do not affect acc. The byte with in_last = 1 is dropped and returns the FSM to S_HDR.
- Parity byte processing: parity_done = 1, err = (byte ≠ acc), dest_valid = 0.
- Holding buffer: circular FIFO of {last, data}, with pointer wrap at HOLD_DEPTH.
  - in_ready = !full. It is registered from occupancy and never depends on out_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - No push occurs when full. out_data/out_last are don't-care when out_valid = 0.
- Every byte accepted outside S_DISCARD is pushed, header and parity included.

## Timing
- Reset (synchronous, held ≥1 cycle): buffer empty, in_ready = 0 while reset is high and 1 on the first cycle after release. All other outputs are 0, state S_HDR, acc = cnt = 0.
- Reset during a packet aborts it. Buffered bytes are lost and status flags clear.
- Latency: a byte accepted at edge N into an empty buffer gives out_valid = 1 with that byte after edge N, i.e. visible in cycle N+1.
- Status flags and dest/dest_valid update at the edge that accepts the relevant byte, so they are visible the following cycle.
- Occupancy reaching HOLD_DEPTH at edge N gives in_ready = 0 in cycle N+1. A pop at edge M gives in_ready = 1 in cycle M+1.
- A header accepted in the cycle right after a parity byte clears the sticky flags one cycle after they were set. Both events must be honoured.
- Sustained throughput is one byte/cycle when out_ready = 1 continuously.

## Test plan
- XOR mode, DW = 8: send 0x0D, 0x11, 0x22, 0x33, 0x0D(last) with out_ready = 1 -> same five bytes out, out_last on 0x0D, dest = 1, parity_done = 1, err = 0, len_err = 0.
- PARITY_MODE = 1, same payload, parity 0x73 -> err = 0. Repeat with parity 0x74 -> err = 1.
- out_ready = 0, stream 6 bytes -> in_ready low after 4 accepted. Raise out_ready -> FIFO order preserved across pointer wrap, no loss or duplication.
- Header 0x0D (L = 3), in_last on the 2nd payload byte -> len_err = 1, err evaluated against acc of 0x0D^0x11 (0x1C).
- Header 0x09 (L = 2), payload 0x11, 0x22, then 0x3A, 0x55, 0x66(last) -> 0x3A treated as parity, err = 0, len_err = 1, 0x55/0x66 not output.
- Runt header 0x05 with in_last, then reset asserted mid-packet -> flags set to 1 after the runt; after reset all outputs 0 and buffer empty.
